popcnt5_seq_ctrl: RTL and testbench
===================================

// Module: popcnt5_seq_ctrl
// PURPOSE
//  Sequencer that time-shares one 5-input ones-count unit to compute the
//  population count of a DATA_W-bit word, 5 bits per cycle.
//  Accepts a word on a valid/ready input, walks its 5-bit chunks LSB-first
//  through the shared unit, and accumulates the chunk counts.
//  Presents the total and a threshold flag on a valid/ready output.
//  Front end for the power-aware synthesis benchmarks that need wide ones-counts.
// PARAMETERS
//  DATA_W   32                       input word width, >= 5
//  CNT_W    $clog2(DATA_W+1)         localparam: count/threshold width
//  NCHUNK   (DATA_W+4)/5             localparam: chunks per word (7 at default)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  clear      in   1       sync abort: drop any word/result, return to IDLE
//  in_valid   in   1       input word valid
//  in_ready   out  1       high only in IDLE (and clear low)
//  in_data    in   DATA_W  word to count
//  in_thr     in   CNT_W   threshold, captured with in_data
//  out_valid  out  1       result valid, held until accepted
//  out_ready  in   1       result consumer ready
//  out_count  out  CNT_W   number of ones in accepted word
//  out_ge     out  1       out_count >= captured threshold
//  busy       out  1       high in RUN or DONE
// BEHAVIOUR
//  - Reset (async): state IDLE; out_valid=0, out_count=0, out_ge=0, busy=0,
//    in_ready=1, shift reg/chunk counter/acc/thr regs = 0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid & ~clear at an edge: load shift reg with in_data
//      (zero-extended to NCHUNK*5 bits), latch in_thr, acc=0, chunk cnt=0 -> RUN.
//    RUN: each edge: acc += popcnt5(shift[4:0]); shift >>= 5; cnt++.
//      The edge that performs the NCHUNK-th add -> DONE.
//      out_count/out_ge update on that same edge.
//    DONE: out_valid=1. out_valid & out_ready -> IDLE. out_count/out_ge stable.
//  - Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
//    No overlap: the next word is accepted no earlier than 1 cycle after out handshake.
//  - Width: acc is CNT_W bits. Max sum DATA_W cannot overflow.
//    Pad bits of the last chunk are 0.
//  - clear (sync) from any state -> IDLE next edge, out_valid=0, result lost.
//    clear wins over in_valid in IDLE: no accept. clear wins over out handshake.
//  - in_valid outside IDLE is ignored; in_data need not be held after accept.
//  - out_ready while out_valid=0 has no effect.
//  - Async rst mid-RUN/DONE: outputs return to reset values immediately.
// STRUCTURE
//  - Shared package popcnt_pkg:
//    - CHUNK_W = 5.
//    - state enum {IDLE, RUN, DONE}.
//    - function nchunk(w) = (w+CHUNK_W-1)/CHUNK_W.
//  - One sub-module: popcnt5_unit, combinational 5-in ones count, 3-bit count out.
//    It is the shared resource; exactly one instance.
//  - Top holds FSM, shift reg, chunk counter ($clog2(NCHUNK+1) bits), acc, thr reg.
// TESTING (DATA_W=32, NCHUNK=7)
//  1. Assert rst -> out_valid=0, busy=0, in_ready=1, out_count=0, out_ge=0.
//  2. in_data=0xFFFFFFFF, in_thr=16 -> out_valid 7 cycles after accept, count=32, ge=1.
//  3. in_data=0x80000000, in_thr=2 (bit in padded chunk) -> count=1, ge=0;
//     in_data=0 -> count=0.
//  4. in_data=0x0F0F0F0F, out_ready low 5 cycles -> count=16 held,
//     in_ready=0, extra in_valid ignored.
//  5. clear during RUN after 3 chunks -> IDLE next edge, out_valid never high;
//     next word 0x00000007 -> count=3.
//  6. Async rst mid-RUN -> immediate reset values; next 0xAAAAAAAA, in_thr=16
//     -> count=16, ge=1.

Source files
------------

// File: rtl/popcnt_pkg.sv
// Shared definitions for the time-shared ones-count sequencer:
// chunk width, sequencer state encoding and the chunk-count helper.
package popcnt_pkg;

  localparam int CHUNK_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int w);
    return (w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/popcnt5_unit.sv
// Combinational ones count of a 5-bit chunk; the single shared
// counting resource that the sequencer walks a word through.
module popcnt5_unit
  import popcnt_pkg::*;
(
  input  logic [CHUNK_W-1:0] bits,
  output logic [2:0]         count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      count = count + {2'b00, bits[i]};
    end
  end

endmodule

// File: rtl/popcnt5_seq_ctrl.sv
// Sequencer computing the population count of a DATA_W-bit word five bits
// per cycle through one shared popcnt5_unit, with a threshold compare.
module popcnt5_seq_ctrl
  import popcnt_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_thr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ge,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid, once raised, holds with stable data until accepted.

  localparam int NCHUNK = nchunk(DATA_W);
  localparam int SH_W   = NCHUNK * CHUNK_W;
  localparam int CC_W   = $clog2(NCHUNK + 1);

  state_t            state;
  state_t            state_nxt;
  logic [SH_W-1:0]   shift_q;
  logic [CC_W-1:0]   cnt_q;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  thr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ge_q;

  logic [2:0]        chunk_cnt;
  logic [CNT_W-1:0]  sum;
  logic              last_chunk;
  logic              accept;

  popcnt5_unit u_unit (
    .bits  (shift_q[CHUNK_W-1:0]),
    .count (chunk_cnt)
  );

  assign sum        = acc_q + CNT_W'(chunk_cnt);
  assign last_chunk = (cnt_q == CC_W'(NCHUNK - 1));
  assign accept     = (state == IDLE) && in_valid && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clear overrides every other transition, including the output handshake.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = RUN;
        RUN:     if (last_chunk) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Word is zero-extended so pad bits of the last chunk count as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      thr_q   <= '0;
      count_q <= '0;
      ge_q    <= 1'b0;
    end else if (accept) begin
      shift_q <= SH_W'(in_data);
      thr_q   <= in_thr;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state == RUN && !clear) begin
      acc_q   <= sum;
      shift_q <= shift_q >> CHUNK_W;
      cnt_q   <= cnt_q + CC_W'(1);
      if (last_chunk) begin
        count_q <= sum;
        ge_q    <= (sum >= thr_q);
      end
    end
  end

  assign in_ready  = (state == IDLE) && !clear;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_count = count_q;
  assign out_ge    = ge_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_popcnt5_seq_ctrl.sv
// Self-checking bench for popcnt5_seq_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_popcnt5_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int NCHUNK = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CNT_W-1:0]  in_thr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  out_count;
  logic              out_ge;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  popcnt5_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_thr    (in_thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_ge    (out_ge),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding accepted word as {ge, count}; at most one at a time.
  logic [CNT_W:0] exp_q[$];
  int cyc = 0;
  int due = 0;

  function automatic logic model_valid();
    return (exp_q.size() != 0) && (cyc >= due);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      logic v_before;
      logic [CNT_W-1:0] c;
      v_before = model_valid();
      cyc++;
      if (clear) begin
        exp_q.delete();
      end else if (exp_q.size() == 0 && in_valid) begin
        c = CNT_W'($countones(in_data));
        exp_q.push_back({(c >= in_thr), c});
        due = cyc + NCHUNK;
      end else if (v_before && out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    #1;
    chk("out_valid", out_valid, model_valid());
    chk("busy", busy, exp_q.size() != 0);
    chk("in_ready", in_ready, (exp_q.size() == 0) && !clear);
    if (model_valid() && out_valid) begin
      chk("out_count", out_count, exp_q[0][CNT_W-1:0]);
      chk("out_ge", out_ge, exp_q[0][CNT_W]);
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one word in IDLE; returns with in_valid dropped, one negedge after accept.
  task automatic send(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_thr   = t;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_thr   = CNT_W'($urandom_range(0, 63));
  endtask

  task automatic run_word(input string name, input logic [DATA_W-1:0] d,
                          input logic [CNT_W-1:0] t, input int exp_cnt,
                          input logic exp_ge, input int hold);
    int n;
    send(d, t);
    n = 0;
    #2;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk({name, "_latency"}, n, NCHUNK);
    chk({name, "_count"}, out_count, exp_cnt);
    chk({name, "_ge"}, out_ge, exp_ge);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      #2;
      chk({name, "_held_valid"}, out_valid, 1'b1);
      chk({name, "_held_count"}, out_count, exp_cnt);
      chk({name, "_in_ready"}, in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    chk({name, "_released"}, out_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ge", out_ge, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_word("all_ones", 32'hFFFF_FFFF, 6'd16, 32, 1'b1, 0);
    run_word("pad_bit", 32'h8000_0000, 6'd2, 1, 1'b0, 0);
    run_word("zero", 32'h0000_0000, 6'd0, 0, 1'b1, 0);
    run_word("nibbles", 32'h0F0F_0F0F, 6'd17, 16, 1'b0, 5);

    // clear after three chunks
    send(32'hFFFF_FFFF, 6'd1);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #2;
    chk("clear_busy", busy, 1'b0);
    chk("clear_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      chk("clear_no_valid", out_valid, 1'b0);
    end
    run_word("after_clear", 32'h0000_0007, 6'd3, 3, 1'b1, 0);

    // asynchronous reset mid-run
    send(32'hFFFF_FFFF, 6'd0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_count", out_count, 0);
    chk("arst_out_ge", out_ge, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_word("after_arst", 32'hAAAA_AAAA, 6'd16, 16, 1'b1, 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 7) == 0) ? '1 : DATA_W'($urandom);
      in_thr    = CNT_W'($urandom_range(0, 33));
      out_ready = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
